// File: rtl/timer_ctrl.sv
// timer_ctrl: bus-mapped interval timer with idle, periodic and one-shot modes.
// Optional prescaler compiled in with `define TIMER_PRESCALER_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | counter stopped, COUNT holds, EN reads 0
//   ST_RUN  | counter advances once per tick, terminal events set PEND
//
// Register map (word index): 0 CTRL {IE,ONESHOT,EN}, 1 LOAD, 2 COUNT (RO),
// 3 STATUS {RUN,PEND(W1C)}, 4 PSC (prescaler build only), 5-7 unmapped.
module timer_ctrl #(
  parameter int CNT_W = 32,
  parameter int PSC_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_en,
  input  logic        bus_we,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        irq
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ie;
  logic             r_oneshot;
  logic             r_pend;
  logic [CNT_W-1:0] r_load;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_terminal;
  logic             w_start;
  logic             w_tick;
  logic             w_run;
  logic             w_wr;
  logic             w_rd;
  logic             w_ctrl_wr;
  logic             w_load_wr;
  logic             w_stat_wr;
  logic [31:0]      w_psc_rd;
  logic [31:0]      w_rdata;
  logic [31:0]      r_rdata;
  logic             r_ready;
  logic             w_unused_bits;

  assign w_wr      = bus_en & bus_we;
  assign w_rd      = bus_en & ~bus_we;
  assign w_ctrl_wr = w_wr & (bus_addr == 3'd0);
  assign w_load_wr = w_wr & (bus_addr == 3'd1);
  assign w_stat_wr = w_wr & (bus_addr == 3'd3);
  assign w_run     = (r_state == ST_RUN);

  // Upper write-data bits beyond each register width are intentionally dropped.
  assign w_unused_bits = ^bus_wdata;

`ifdef TIMER_PRESCALER_EN
  logic             w_psc_wr;
  logic [PSC_W-1:0] r_psc;
  logic [PSC_W-1:0] r_psc_cnt;

  assign w_psc_wr = w_wr & (bus_addr == 3'd4);
  assign w_tick   = (r_psc_cnt == r_psc);
  assign w_psc_rd = 32'(r_psc);

  // Prescaler: counts 0..PSC while running; restarts on start or PSC write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_psc     <= '0;
      r_psc_cnt <= '0;
    end else begin
      if (w_psc_wr) begin
        r_psc <= bus_wdata[PSC_W-1:0];
      end
      if (w_psc_wr || w_start) begin
        r_psc_cnt <= '0;
      end else if (w_run) begin
        r_psc_cnt <= w_tick ? '0 : r_psc_cnt + PSC_W'(1);
      end
    end
  end
`else
  localparam int psc_w_unused = PSC_W;

  assign w_tick   = 1'b1;
  assign w_psc_rd = 32'd0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and counter update; a stop write overrides any tick in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_terminal  = 1'b0;
    w_start     = 1'b0;
    if (w_ctrl_wr && !bus_wdata[0]) begin
      w_state_nxt = ST_IDLE;
    end else if (w_ctrl_wr && (r_state == ST_IDLE) && (r_load != '0)) begin
      w_state_nxt = ST_RUN;
      w_count_nxt = '0;
      w_start     = 1'b1;
    end else if ((r_state == ST_RUN) && w_tick) begin
      if (r_load == '0) begin
        // LOAD cleared while running: stop without a terminal event.
        w_state_nxt = ST_IDLE;
      end else if (r_count >= (r_load - CNT_ONE)) begin
        // ">=" rather than "==" so a shrunken LOAD ends the period at once.
        w_terminal  = 1'b1;
        w_count_nxt = '0;
        if (r_oneshot) begin
          w_state_nxt = ST_IDLE;
        end
      end else begin
        w_count_nxt = r_count + CNT_ONE;
      end
    end
  end

  // Control, reload, count and pending registers; terminal set beats W1C clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ie      <= 1'b0;
      r_oneshot <= 1'b0;
      r_pend    <= 1'b0;
      r_load    <= '0;
      r_count   <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_ie      <= bus_wdata[2];
        r_oneshot <= bus_wdata[1];
      end
      if (w_load_wr) begin
        r_load <= bus_wdata[CNT_W-1:0];
      end
      r_count <= w_count_nxt;
      if (w_terminal) begin
        r_pend <= 1'b1;
      end else if (w_stat_wr && bus_wdata[0]) begin
        r_pend <= 1'b0;
      end
    end
  end

  // Read data mux over pre-edge register state.
  always_comb begin
    w_rdata = 32'd0;
    case (bus_addr)
      3'd0:    w_rdata = {29'd0, r_ie, r_oneshot, w_run};
      3'd1:    w_rdata = 32'(r_load);
      3'd2:    w_rdata = 32'(r_count);
      3'd3:    w_rdata = {30'd0, w_run, r_pend};
      3'd4:    w_rdata = w_psc_rd;
      default: w_rdata = 32'd0;
    endcase
  end

  // Bus response: one-cycle ready for every access, read data held until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ready <= bus_en;
      if (w_rd) begin
        r_rdata <= w_rdata;
      end
    end
  end

  assign bus_ready = r_ready;
  assign bus_rdata = r_rdata;
  assign irq       = r_pend & r_ie;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: table-driven periodic/W1C sequence plus hand-written
// one-shot, guard, LOAD shrink, reset and prescaler sequences. Read results
// are checked from a scoreboard queue when bus_ready arrives.
module tb_timer_ctrl;

  logic        clk;
  logic        rst;
  logic        bus_en;
  logic        bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic        q_rd[$];
  logic [31:0] q_exp[$];
  string       q_nm[$];

  logic        m_isrd;
  logic [31:0] m_exp;
  string       m_nm;

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
    logic        irq_exp;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  timer_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus_en    (bus_en),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void add(logic we, logic [2:0] a, logic [31:0] d,
                              logic [31:0] e, logic ie, string nm);
    vec_t v;
    v.we      = we;
    v.addr    = a;
    v.wdata   = d;
    v.rexp    = e;
    v.irq_exp = ie;
    v.nm      = nm;
    tbl.push_back(v);
  endfunction

  // One bus access starting at the current falling edge, sampled at the next rising edge.
  task automatic acc(input logic we, input logic [2:0] a, input logic [31:0] d,
                     input logic [31:0] e, input string nm);
    bus_en    = 1'b1;
    bus_we    = we;
    bus_addr  = a;
    bus_wdata = d;
    q_rd.push_back(!we);
    q_exp.push_back(e);
    q_nm.push_back(nm);
    @(negedge clk);
    bus_en = 1'b0;
    bus_we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    acc(1'b1, a, d, 32'd0, "wr");
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    acc(1'b0, a, 32'd0, e, nm);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_irq(input string nm, input logic e);
    chk(nm, {31'd0, irq}, {31'd0, e});
  endtask

  // Scoreboard: every bus_ready retires the oldest outstanding access.
  always @(negedge clk) begin
    if (bus_ready) begin
      if (q_rd.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: got 1, expected 0");
      end else begin
        m_isrd = q_rd.pop_front();
        m_exp  = q_exp.pop_front();
        m_nm   = q_nm.pop_front();
        if (m_isrd) chk(m_nm, bus_rdata, m_exp);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic bad;
    rst       = 1'b1;
    bus_en    = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 3'd0;
    bus_wdata = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_rdata", bus_rdata, 32'd0);
    chk("rst_ready", {31'd0, bus_ready}, 32'd0);
    chk_irq("rst_irq", 1'b0);
    for (int a = 0; a < 6; a++) rd(3'(a), 32'd0, $sformatf("rst_reg%0d", a));

    // Periodic LOAD=5 with IE; CTRL write edge is E, entry k is sampled at E+k.
    add(1, 3'd1, 32'd5, 0, 0, "p_load");
    add(1, 3'd0, 32'd5, 0, 0, "p_ctrl");
    add(0, 3'd2, 0, 32'd0, 0, "p_cnt0");
    add(0, 3'd2, 0, 32'd1, 0, "p_cnt1");
    add(0, 3'd2, 0, 32'd2, 0, "p_cnt2");
    add(0, 3'd2, 0, 32'd3, 0, "p_cnt3");
    add(0, 3'd2, 0, 32'd4, 1, "p_cnt4");
    add(0, 3'd2, 0, 32'd0, 1, "p_cnt_wrap");
    add(0, 3'd3, 0, 32'd3, 1, "p_status");
    add(0, 3'd0, 0, 32'd5, 1, "p_ctrl_rd");
    add(1, 3'd3, 32'd1, 0, 0, "p_w1c");
    add(0, 3'd3, 0, 32'd2, 1, "p_status_clr");
    add(0, 3'd3, 0, 32'd3, 1, "p_status_2nd");
    add(0, 3'd1, 0, 32'd5, 1, "p_load_rd");
    add(0, 3'd2, 0, 32'd2, 1, "p_cnt_mid");
    add(0, 3'd6, 0, 32'd0, 1, "p_unmapped");
    add(1, 3'd3, 32'd1, 0, 1, "p_w1c_race");
    add(0, 3'd3, 0, 32'd3, 1, "p_race_pend");
    add(1, 3'd3, 32'd1, 0, 0, "p_w1c_late");
    add(0, 3'd3, 0, 32'd2, 0, "p_late_clr");
    add(1, 3'd0, 32'd0, 0, 0, "p_stop");
    for (int i = 0; i < tbl.size(); i++) begin
      acc(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rexp, tbl[i].nm);
      chk_irq({tbl[i].nm, "_irq"}, tbl[i].irq_exp);
    end

    // One-shot LOAD=3.
    wr(3'd1, 32'd3);
    wr(3'd0, 32'd7);
    idle(2);
    chk_irq("os_irq_early", 1'b0);
    rd(3'd3, 32'd2, "os_run_before");
    chk_irq("os_irq_rise", 1'b1);
    rd(3'd3, 32'd1, "os_status_after");
    rd(3'd0, 32'd6, "os_ctrl_en0");
    rd(3'd2, 32'd0, "os_count0");
    wr(3'd3, 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (irq !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    chk("os_no_more_irq", {31'd0, bad}, 32'd0);
    rd(3'd3, 32'd0, "os_no_more_pend");

    // Guards: EN with LOAD=0 never runs.
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd1);
    rd(3'd3, 32'd0, "g_status");
    rd(3'd0, 32'd0, "g_ctrl");
    wr(3'd0, 32'd5);
    rd(3'd0, 32'd4, "g_ctrl_ie_only");
    rd(3'd3, 32'd0, "g_status2");

    // LOAD=0 written during RUN stops without a terminal event.
    wr(3'd1, 32'd4);
    wr(3'd0, 32'd1);
    wr(3'd1, 32'd0);
    idle(1);
    rd(3'd3, 32'd0, "z_status");
    rd(3'd2, 32'd1, "z_count_hold");

    // LOAD shrink 100 -> 10 at COUNT=50.
    wr(3'd1, 32'd100);
    wr(3'd0, 32'd1);
    idle(49);
    rd(3'd2, 32'd49, "s_count49");
    wr(3'd1, 32'd10);
    rd(3'd2, 32'd51, "s_count51");
    rd(3'd2, 32'd0, "s_terminal");
    rd(3'd3, 32'd3, "s_status");
    wr(3'd0, 32'd0);
    rd(3'd2, 32'd2, "s_stop_hold1");
    rd(3'd2, 32'd2, "s_stop_hold2");

    // Reset at COUNT=7 with PEND set and a read in flight.
    wr(3'd1, 32'd20);
    wr(3'd0, 32'd5);
    chk_irq("r_irq_before", 1'b1);
    idle(6);
    rd(3'd2, 32'd6, "r_count6");
    rst      = 1'b1;
    bus_en   = 1'b1;
    bus_we   = 1'b0;
    bus_addr = 3'd2;
    @(negedge clk);
    rst    = 1'b0;
    bus_en = 1'b0;
    chk("r_ready", {31'd0, bus_ready}, 32'd0);
    chk("r_rdata", bus_rdata, 32'd0);
    chk_irq("r_irq", 1'b0);
    for (int a = 0; a < 5; a++) rd(3'(a), 32'd0, $sformatf("r_reg%0d", a));
    chk_irq("r_irq_after", 1'b0);

`ifdef TIMER_PRESCALER_EN
    wr(3'd4, 32'd2);
    wr(3'd1, 32'd4);
    wr(3'd0, 32'd5);
    rd(3'd4, 32'd2, "psc_rd");
    chk_irq("psc_irq_start", 1'b0);
    idle(10);
    chk_irq("psc_irq_e11", 1'b0);
    idle(1);
    chk_irq("psc_irq_e12", 1'b1);
`else
    wr(3'd4, 32'd2);
    rd(3'd4, 32'd0, "psc_unmapped");
`endif

    idle(3);
    chk("sb_drain", 32'(q_rd.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
